// File: rtl/dual_port_ram_be.sv
// rtl/dual_port_ram_be.sv - true dual-port byte-enable RAM with clear-on-reset sequencer
// Optional output register stage: define DUAL_PORT_RAM_OUTREG_EN (read latency 2).
module dual_port_ram_be #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  output logic                    collision,
  input  logic                    a_en,
  input  logic                    a_we,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_rvalid,
  input  logic                    b_en,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_rvalid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    run;
  logic                    a_in, b_in;
  logic                    a_wr, b_wr, a_rd, b_rd;
  logic                    same_addr;
  logic [DATA_WIDTH-1:0]   a_merged, b_merged;
  logic [DATA_WIDTH-1:0]   a_rdata_s, b_rdata_s;
  logic                    a_rvalid_s, b_rvalid_s;

  assign run       = (state == S_RUN);
  assign a_in      = ({1'b0, a_addr} < LIMIT);
  assign b_in      = ({1'b0, b_addr} < LIMIT);
  assign a_wr      = run && a_en && a_we && a_in;
  assign b_wr      = run && b_en && b_we && b_in;
  assign a_rd      = run && a_en && !a_we;
  assign b_rd      = run && b_en && !b_we;
  assign same_addr = (a_addr == b_addr);

  // Post-write word at each port's address; A owns lanes both ports enable.
  // The same merged word is the write-first read data.
  always_comb begin
    a_merged = mem[a_addr];
    b_merged = mem[b_addr];
    for (int l = 0; l < NB; l++) begin
      if (a_wr && a_be[l])
        a_merged[8*l +: 8] = a_wdata[8*l +: 8];
      else if (b_wr && same_addr && b_be[l])
        a_merged[8*l +: 8] = b_wdata[8*l +: 8];
      if (a_wr && same_addr && a_be[l])
        b_merged[8*l +: 8] = a_wdata[8*l +: 8];
      else if (b_wr && b_be[l])
        b_merged[8*l +: 8] = b_wdata[8*l +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[init_cnt] <= '0;
    end else begin
      if (a_wr) mem[a_addr] <= a_merged;
      if (b_wr) mem[b_addr] <= b_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      init_busy  <= 1'b1;
      collision  <= 1'b0;
      a_rvalid_s <= 1'b0;
      b_rvalid_s <= 1'b0;
      a_rdata_s  <= '0;
      b_rdata_s  <= '0;
    end else begin
      collision  <= a_wr && b_wr && same_addr;
      a_rvalid_s <= a_rd;
      b_rvalid_s <= b_rd;
      if (a_rd) a_rdata_s <= a_in ? a_merged : '0;
      if (b_rd) b_rdata_s <= b_in ? b_merged : '0;
      case (state)
        S_INIT: begin
          if (init_cnt == LAST) begin
            state     <= S_RUN;
            init_cnt  <= '0;
            init_busy <= 1'b0;
          end else begin
            init_cnt  <= init_cnt + 1'b1;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef DUAL_PORT_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic                  a_rvalid_q, b_rvalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rdata_q  <= a_rdata_s;
      b_rdata_q  <= b_rdata_s;
      a_rvalid_q <= a_rvalid_s;
      b_rvalid_q <= b_rvalid_s;
    end
  end

  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
`else
  assign a_rdata  = a_rdata_s;
  assign b_rdata  = b_rdata_s;
  assign a_rvalid = a_rvalid_s;
  assign b_rvalid = b_rvalid_s;
`endif

endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb/tb_dual_port_ram_be.sv - scoreboard bench for dual_port_ram_be (DEPTH 16 and DEPTH 12 instances)
module tb_dual_port_ram_be;

`ifdef DUAL_PORT_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, a_we, b_en, b_we;
  logic [1:0]  a_be, b_be;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;

  logic        init_busy, collision, a_rvalid, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        init_busy12, collision12, a_rvalid12, b_rvalid12;
  logic [15:0] a_rdata12, b_rdata12;

  always #5 clk = ~clk;

  dual_port_ram_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16)) u_dut (
    .clk(clk), .rst(rst), .init_busy(init_busy), .collision(collision),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid));

  dual_port_ram_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst(rst), .init_busy(init_busy12), .collision(collision12),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata12), .a_rvalid(a_rvalid12),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata12), .b_rvalid(b_rvalid12));

  wire [3:0]  obs_v = {b_rvalid12, a_rvalid12, b_rvalid, a_rvalid};
  wire [63:0] obs_d = {b_rdata12, a_rdata12, b_rdata, a_rdata};

  typedef struct packed {
    logic [3:0]  v;
    logic [63:0] d;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m [2][16];
  logic [15:0] last [4];
  int          cnt [2];
  logic        busy [2];
  int          checks = 0;
  int          errors = 0;
  int          n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference word after this edge's writes: B's lanes first, then A's on top.
  function automatic logic [15:0] post_word(input int i, input logic [3:0] addr,
                                            input logic aw, input logic bw);
    logic [15:0] w;
    w = m[i][addr];
    if (bw && b_addr == addr) begin
      if (b_be[0]) w[7:0]  = b_wdata[7:0];
      if (b_be[1]) w[15:8] = b_wdata[15:8];
    end
    if (aw && a_addr == addr) begin
      if (a_be[0]) w[7:0]  = a_wdata[7:0];
      if (a_be[1]) w[15:8] = a_wdata[15:8];
    end
    return w;
  endfunction

  task automatic tick();
    exp_t        e;
    logic [1:0]  ecol;
    logic        aw, bw;
    logic [15:0] na, nb;
    int          depth;
    @(posedge clk);
    e    = '0;
    ecol = '0;
    if (rst) begin
      q.delete();
      for (int j = 0; j < 4; j++) last[j] = '0;
      for (int i = 0; i < 2; i++) begin cnt[i] = 0; busy[i] = 1'b1; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        depth = (i == 0) ? 16 : 12;
        if (busy[i]) begin
          m[i][cnt[i]] = '0;
          if (cnt[i] == depth - 1) busy[i] = 1'b0;
          cnt[i]++;
        end else begin
          aw = a_en && a_we && (int'(a_addr) < depth);
          bw = b_en && b_we && (int'(b_addr) < depth);
          if (a_en && !a_we) begin
            e.v[2*i] = 1'b1;
            last[2*i] = (int'(a_addr) < depth) ? post_word(i, a_addr, aw, bw) : 16'h0;
          end
          if (b_en && !b_we) begin
            e.v[2*i+1] = 1'b1;
            last[2*i+1] = (int'(b_addr) < depth) ? post_word(i, b_addr, aw, bw) : 16'h0;
          end
          ecol[i] = aw && bw && (a_addr == b_addr);
          na = post_word(i, a_addr, aw, bw);
          nb = post_word(i, b_addr, aw, bw);
          if (aw) m[i][a_addr] = na;
          if (bw) m[i][b_addr] = nb;
        end
      end
      e.d = {last[3], last[2], last[1], last[0]};
      q.push_back(e);
    end
    @(negedge clk);
    check("init_busy", 64'({init_busy12, init_busy}), 64'({busy[1], busy[0]}));
    check("collision", 64'({collision12, collision}), 64'(ecol));
    if (rst) begin
      check("rst_rvalid", 64'(obs_v), 64'h0);
      check("rst_rdata", obs_d, 64'h0);
    end else if (q.size() >= LAT) begin
      e = q.pop_front();
      check("rvalid", 64'(obs_v), 64'(e.v));
      check("rdata", obs_d, e.d);
    end
    a_en = 1'b0;
    b_en = 1'b0;
  endtask

  task automatic set_a(input logic en, input logic we, input logic [1:0] be,
                       input logic [3:0] addr, input logic [15:0] wd);
    a_en = en; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [1:0] be,
                       input logic [3:0] addr, input logic [15:0] wd);
    b_en = en; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Reads are issued during the clear so that any leaked rvalid is caught.
  task automatic init_wait();
    n = 0;
    while (init_busy && n < 100) begin
      set_a(1'b1, 1'b0, 2'b00, 4'(n), 16'h0);
      tick();
      n++;
    end
    check("init_cycles", 64'(n), 64'd16);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, 1'b0, 2'b00, 4'(i), 16'h0);
      set_b(1'b1, 1'b0, 2'b00, 4'(15 - i), 16'h0);
      tick();
    end
    idle(LAT);
  endtask

  initial begin
    rst = 1'b1;
    set_a(1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
    set_b(1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
    #1;
    check("reset_busy", 64'(init_busy), 64'h1);
    check("reset_collision", 64'(collision), 64'h0);
    check("reset_rvalid", 64'({b_rvalid, a_rvalid}), 64'h0);
    check("reset_rdata", 64'({b_rdata, a_rdata}), 64'h0);
    idle(3);
    rst = 1'b0;
    init_wait();
    read_all();

    // byte enables
    set_a(1'b1, 1'b1, 2'b11, 4'd3, 16'hABCD); tick();
    set_a(1'b1, 1'b1, 2'b01, 4'd3, 16'h12EF); tick();
    set_b(1'b1, 1'b0, 2'b00, 4'd3, 16'h0);    tick();
    idle(2);
    check("byte_enable", 64'(b_rdata), 64'hABEF);

    // write-write collisions, full and disjoint masks
    set_a(1'b1, 1'b1, 2'b11, 4'd5, 16'h1111);
    set_b(1'b1, 1'b1, 2'b11, 4'd5, 16'h2222);
    tick();
    check("collision_full", 64'(collision), 64'h1);
    set_b(1'b1, 1'b0, 2'b00, 4'd5, 16'h0); tick();
    idle(2);
    check("collision_full_data", 64'(b_rdata), 64'h1111);
    set_a(1'b1, 1'b1, 2'b10, 4'd5, 16'h1111);
    set_b(1'b1, 1'b1, 2'b01, 4'd5, 16'h2222);
    tick();
    check("collision_split", 64'(collision), 64'h1);
    set_a(1'b1, 1'b0, 2'b00, 4'd5, 16'h0); tick();
    idle(2);
    check("collision_split_data", 64'(a_rdata), 64'h1122);

    // read during write on the other port
    set_a(1'b1, 1'b1, 2'b11, 4'd7, 16'hBEEF);
    set_b(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
    tick();
    idle(2);
    check("write_first", 64'(b_rdata), 64'hBEEF);

    // out of range on the DEPTH=12 instance
    set_a(1'b1, 1'b1, 2'b11, 4'd13, 16'h5555); tick();
    set_a(1'b1, 1'b0, 2'b00, 4'd3, 16'h0);     tick();
    set_a(1'b1, 1'b0, 2'b00, 4'd13, 16'h0);    tick();
    idle(2);
    check("oor_read12", 64'(a_rdata12), 64'h0);
    check("inrange_read16", 64'(a_rdata), 64'h5555);
    read_all();

    // random mixed traffic, biased toward colliding and out-of-range addresses
    for (int i = 0; i < 300; i++) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 3) + ($urandom_range(0, 1) != 0 ? 10 : 0)), 16'($urandom));
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 3) + ($urandom_range(0, 1) != 0 ? 10 : 0)), 16'($urandom));
      tick();
    end
    idle(LAT);
    read_all();

    // reset in the middle of a read
    set_a(1'b1, 1'b1, 2'b11, 4'd2, 16'h2A2A); tick();
    set_a(1'b1, 1'b0, 2'b00, 4'd2, 16'h0);    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", 64'(a_rvalid), 64'h0);
    check("mid_rst_rdata", 64'(a_rdata), 64'h0);
    check("mid_rst_busy", 64'(init_busy), 64'h1);
    idle(2);
    rst = 1'b0;
    init_wait();
    set_a(1'b1, 1'b0, 2'b00, 4'd2, 16'h0);    tick();
    set_a(1'b1, 1'b1, 2'b11, 4'd7, 16'hBEEF); tick();
    set_b(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);    tick();
    idle(2);
    check("post_rst_read", 64'(b_rdata), 64'hBEEF);
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_be.md
# dual_port_ram_be

Single-clock, parametrised true dual-port RAM with per-byte write enables, deterministic collision resolution and a self-clearing initialisation sequencer. Two independent ports (A, B) share one storage array. Both ports may read or write every cycle. The block is the generic storage primitive for buffers and register files; it replaces hand-sized per-width RAMs.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 4, address width in bits
- DEPTH, 16, number of words; 1 ≤ DEPTH ≤ 2**ADDR_WIDTH
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- init_busy  out  1  high while the array is being cleared; requests are ignored
- collision  out  1  one-cycle pulse: both ports wrote the same address
- a_en, b_en  in  1  port request strobe
- a_we, b_we  in  1  1 = write, 0 = read (qualified by *_en)
- a_be, b_be  in  DATA_WIDTH/8  byte-lane write enables
- a_addr, b_addr  in  ADDR_WIDTH  word address
- a_wdata, b_wdata  in  DATA_WIDTH  write data
- a_rdata, b_rdata  out  DATA_WIDTH  read data; holds last value when rvalid is low
- a_rvalid, b_rvalid  out  1  one-cycle pulse marking a_rdata/b_rdata valid

## Operation
- FSM states:
  - INIT: a counter 0..DEPTH-1 writes zero to one word per cycle. After word DEPTH-1, go to RUN.
  - RUN: normal operation.
- Reset puts the FSM in INIT with the counter at 0. Reset asserted mid-operation aborts all activity and restarts INIT.
- While in INIT, *_en is ignored: no write, no rvalid, no collision.
- Write (en=1, we=1, in range): each byte lane i with be[i]=1 takes wdata[8i+7:8i]; other lanes keep their value. be=0 is a no-op. A write never produces rvalid.
- Read (en=1, we=0, in range): returns the word at addr.
- Out of range (addr ≥ DEPTH): the write is dropped. A read returns 0 with rvalid=1.
- Write-write to the same in-range address:
  - lanes enabled by both ports take A's data;
  - lanes enabled by one port take that port's data;
  - collision=1 for one cycle. It pulses even when the be masks do not overlap.
- Read of an address the other port writes in the same cycle is write-first: it returns the merged post-write word.
- Different addresses never interact.

## Timing
- Reset values: a_rdata=b_rdata=0, a_rvalid=b_rvalid=0, collision=0, init_busy=1.
- init_busy stays 1 during reset and for DEPTH cycles after rst deasserts, then goes 0. The first accepted request is at the first edge with init_busy=0.
- Read latency is 1: a request sampled at edge k drives rdata/rvalid after edge k, and rvalid is high for exactly that cycle.
- Back-to-back reads on every edge give rvalid high continuously, with a new word each cycle.
- Write latency: the array updates at edge k, so a read sampled at edge k+1 sees the new data.
- collision is registered and asserts in the cycle after the colliding edge.

## Configuration
- DUAL_PORT_RAM_OUTREG_EN defined:
  - adds an output register stage on rdata/rvalid;
  - read latency becomes 2;
  - the out-of-range zero response and write-first data are also delayed by 2;
  - collision latency is unchanged at 1;
  - output registers reset to 0.
- Undefined: latency 1 as specified above.

## Test plan
- Init: assert rst for 3 cycles, then release. init_busy stays 1 for exactly 16 cycles. A read of every address then returns 0x0000. Requests issued during init give no rvalid.
- Byte enables: A writes 0xABCD with be=2'b11 to addr 3, then 0x12EF with be=2'b01. B reads addr 3 and gets 0xABEF one cycle later, with b_rvalid pulsed once.
- Collision: same edge, A writes 0x1111 and B writes 0x2222 to addr 5 with be=2'b11. collision pulses once; a read of addr 5 returns 0x1111. Repeat with A be=2'b10 and B be=2'b01: the result is 0x1122 and collision pulses again.
- Read-during-write: word 7 holds 0x0000. A writes 0xBEEF to addr 7 while B reads addr 7 on the same edge. B gets 0xBEEF.
- Out of range: run with DEPTH=12. A writes 0x5555 to addr 13, then reads addr 13: rdata=0x0000 with rvalid=1. Addresses 0..11 are unchanged.
- Reset mid-read: A reads addr 2 and rst asserts before the next edge. a_rvalid and a_rdata go to 0 immediately, and the INIT sequence restarts. With DUAL_PORT_RAM_OUTREG_EN, a read of 0xBEEF appears exactly 2 cycles after the request.
